// File: rtl/cache_pkg.sv
// Shared constants and helpers for the cache replacement unit: policy
// encodings, the random-mode LFSR tap mask and the invalid-way finder.
package cache_pkg;

    localparam int POLICY_FIFO   = 0;
    localparam int POLICY_PLRU   = 1;
    localparam int POLICY_RANDOM = 2;

    // Largest way count the invalid-way finder can scan.
    localparam int MAX_WAYS = 32;

    // Fibonacci taps 16,14,13,11 for a right-shifting register whose output
    // bit is bit 0: feedback is the XOR of bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Index of the lowest zero bit; bits above the real way count must be
    // padded with ones so that they are never chosen.
    function automatic logic [5:0] lowest_zero_idx(input logic [MAX_WAYS-1:0] mask);
        logic [5:0] idx;
        logic       found;
        idx   = 6'd0;
        found = 1'b0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (!found && !mask[i]) begin
                idx   = 6'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // One step of the LFSR: shift right, feedback enters at bit 15.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {^(state & LFSR_TAPS), state[15:1]};
    endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Tree-PLRU walk and update for one set. Node 0 is the root, node n has
// children 2n+1 (lower half) and 2n+2 (upper half); a node bit of 0 points
// at the lower half. Purely combinational.
module plru_tree_logic #(
    parameter int WAY_COUNT = 4
) (
    input  logic [WAY_COUNT-2:0]         tree,
    input  logic [$clog2(WAY_COUNT)-1:0] touch_way,
    output logic [$clog2(WAY_COUNT)-1:0] victim_way,
    output logic [WAY_COUNT-2:0]         next_tree
);

    localparam int IDX_W = $clog2(WAY_COUNT);
    localparam int EXT_W = 2 * WAY_COUNT;

    // The tree is zero-extended so that the walk index, one bit wider than
    // a way index, addresses it exactly, including the overshoot of the last
    // step.
    logic [EXT_W-1:0] tree_ext_s;
    logic [EXT_W-1:0] next_ext_s;
    logic             unused_s;

    assign tree_ext_s = {{(WAY_COUNT + 1){1'b0}}, tree};

    // Follow the node bits from the root down to a leaf to find the victim.
    always_comb begin
        logic [IDX_W:0] node_v;
        logic           bit_v;
        node_v     = {(IDX_W + 1){1'b0}};
        bit_v      = 1'b0;
        victim_way = {IDX_W{1'b0}};
        for (int l = IDX_W - 1; l >= 0; l--) begin
            bit_v         = tree_ext_s[node_v];
            victim_way[l] = bit_v;
            node_v        = (node_v << 1) + {{IDX_W{1'b0}}, 1'b1} + {{IDX_W{1'b0}}, bit_v};
        end
    end

    // Walk the path of the touched way and make each node point away from it.
    always_comb begin
        logic [IDX_W:0] node_v;
        logic           bit_v;
        node_v     = {(IDX_W + 1){1'b0}};
        bit_v      = 1'b0;
        next_ext_s = tree_ext_s;
        for (int l = IDX_W - 1; l >= 0; l--) begin
            bit_v              = touch_way[l];
            next_ext_s[node_v] = ~bit_v;
            node_v             = (node_v << 1) + {{IDX_W{1'b0}}, 1'b1} + {{IDX_W{1'b0}}, bit_v};
        end
    end

    assign next_tree = next_ext_s[WAY_COUNT-2:0];
    assign unused_s  = ^next_ext_s[EXT_W-1:WAY_COUNT-1];

endmodule

// File: rtl/cache_replacement_unit.sv
// Per-set victim-way selector. An invalid way is always preferred; on a
// full set the victim comes from the elaboration-selected policy (FIFO,
// tree-PLRU or pseudo-random). After an accepted fill the unit is busy for
// one cycle so that the tag array can refresh valid_mask.
module cache_replacement_unit
    import cache_pkg::*;
#(
    parameter int          WAY_COUNT = 2,
    parameter int          SET_COUNT = 64,
    parameter int          POLICY    = POLICY_PLRU,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(SET_COUNT)-1:0] set,
    input  logic [$clog2(WAY_COUNT)-1:0] access_way,
    input  logic                         access,
    input  logic [WAY_COUNT-1:0]         valid_mask,
    output logic [$clog2(WAY_COUNT)-1:0] replacement_way,
    input  logic                         taken,
    output logic                         ready
);

    localparam int IDX_W = $clog2(WAY_COUNT);

    // Parameter sanity checks at elaboration.
    if (WAY_COUNT < 2 || WAY_COUNT > MAX_WAYS || (WAY_COUNT & (WAY_COUNT - 1)) != 0) begin : g_bad_ways
        $error("cache_replacement_unit: WAY_COUNT must be a power of two in 2..32");
    end
    if (SET_COUNT < 2 || (SET_COUNT & (SET_COUNT - 1)) != 0) begin : g_bad_sets
        $error("cache_replacement_unit: SET_COUNT must be a power of two, at least 2");
    end
    if (POLICY != POLICY_FIFO && POLICY != POLICY_PLRU && POLICY != POLICY_RANDOM) begin : g_bad_policy
        $error("cache_replacement_unit: unknown POLICY");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("cache_replacement_unit: LFSR_SEED must be non-zero");
    end

    logic             ready_r;
    logic             taken_acc_s;
    logic             access_acc_s;
    logic             full_s;
    logic [MAX_WAYS-1:0] mask_ext_s;
    logic [5:0]       lz_idx_s;
    logic [IDX_W-1:0] policy_way_s;
    logic             unused_top_s;

    // Requests are only honoured while ready; a fill beats a same-cycle hit.
    assign taken_acc_s  = taken & ready_r;
    assign access_acc_s = access & ready_r & ~taken;

    assign full_s       = &valid_mask;
    assign mask_ext_s   = {{(MAX_WAYS - WAY_COUNT){1'b1}}, valid_mask};
    assign lz_idx_s     = lowest_zero_idx(mask_ext_s);
    assign unused_top_s = ^lz_idx_s[5:IDX_W];

    // Victim: first invalid way if the set has one, else the policy's choice.
    always_comb begin
        if (!full_s) begin
            replacement_way = lz_idx_s[IDX_W-1:0];
        end else begin
            replacement_way = policy_way_s;
        end
    end

    // Busy for exactly the cycle after an accepted fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= ~taken_acc_s;
        end
    end

    assign ready = ready_r;

    if (POLICY == POLICY_FIFO) begin : g_fifo
        logic [IDX_W-1:0] fifo_cnt_r [SET_COUNT];
        logic             unused_s;

        // Advance the set's round-robin pointer only when a full set is refilled.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < SET_COUNT; i++) begin
                    fifo_cnt_r[i] <= {IDX_W{1'b0}};
                end
            end else if (taken_acc_s && full_s) begin
                fifo_cnt_r[set] <= fifo_cnt_r[set] + IDX_W'(1'b1);
            end
        end

        assign policy_way_s = fifo_cnt_r[set];
        assign unused_s     = ^{access_way, access_acc_s};

    end else if (POLICY == POLICY_PLRU) begin : g_plru
        logic [WAY_COUNT-2:0] tree_r [SET_COUNT];
        logic [WAY_COUNT-2:0] tree_next_s;
        logic [IDX_W-1:0]     touch_way_s;

        // A fill touches the way being filled, a hit touches the hit way.
        assign touch_way_s = taken_acc_s ? replacement_way : access_way;

        plru_tree_logic #(
            .WAY_COUNT (WAY_COUNT)
        ) u_plru_tree_logic (
            .tree       (tree_r[set]),
            .touch_way  (touch_way_s),
            .victim_way (policy_way_s),
            .next_tree  (tree_next_s)
        );

        // Write back the updated tree of the addressed set on any accepted touch.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < SET_COUNT; i++) begin
                    tree_r[i] <= {(WAY_COUNT - 1){1'b0}};
                end
            end else if (taken_acc_s || access_acc_s) begin
                tree_r[set] <= tree_next_s;
            end
        end

    end else begin : g_random
        logic [15:0] lfsr_r;
        logic        unused_s;

        // Free-running LFSR; requests never perturb the sequence.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lfsr_r <= LFSR_SEED;
            end else begin
                lfsr_r <= lfsr_step(lfsr_r);
            end
        end

        assign policy_way_s = lfsr_r[IDX_W-1:0];
        assign unused_s     = ^{set, access_way, access_acc_s, lfsr_r[15:IDX_W]};
    end

endmodule

// File: tb/tb_cache_replacement_unit.sv
// Bench for cache_replacement_unit: one instance per policy (FIFO and PLRU
// with 4 ways, RANDOM with 2 ways), checked against a scoreboard of
// expected values computed here.
module tb_cache_replacement_unit;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic reset;

    logic [5:0] f_set;  logic [1:0] f_aw;  logic f_acc;  logic f_tk;
    logic [3:0] f_vm;   logic [1:0] f_rw;  logic f_rdy;
    logic [5:0] p_set;  logic [1:0] p_aw;  logic p_acc;  logic p_tk;
    logic [3:0] p_vm;   logic [1:0] p_rw;  logic p_rdy;
    logic [5:0] r_set;  logic       r_aw;  logic r_acc;  logic r_tk;
    logic [1:0] r_vm;   logic       r_rw;  logic r_rdy;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  e;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] m;

    always #5 clk = ~clk;

    cache_replacement_unit #(.WAY_COUNT(4), .SET_COUNT(64), .POLICY(POLICY_FIFO), .LFSR_SEED(16'hACE1)) u_fifo (
        .clk(clk), .reset(reset), .set(f_set), .access_way(f_aw), .access(f_acc),
        .valid_mask(f_vm), .replacement_way(f_rw), .taken(f_tk), .ready(f_rdy));

    cache_replacement_unit #(.WAY_COUNT(4), .SET_COUNT(64), .POLICY(POLICY_PLRU), .LFSR_SEED(16'hACE1)) u_plru (
        .clk(clk), .reset(reset), .set(p_set), .access_way(p_aw), .access(p_acc),
        .valid_mask(p_vm), .replacement_way(p_rw), .taken(p_tk), .ready(p_rdy));

    cache_replacement_unit #(.WAY_COUNT(2), .SET_COUNT(64), .POLICY(POLICY_RANDOM), .LFSR_SEED(16'hACE1)) u_rand (
        .clk(clk), .reset(reset), .set(r_set), .access_way(r_aw), .access(r_acc),
        .valid_mask(r_vm), .replacement_way(r_rw), .taken(r_tk), .ready(r_rdy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        f_set = 6'd0; f_aw = 2'd0; f_acc = 1'b0; f_tk = 1'b0; f_vm = 4'h0;
        p_set = 6'd0; p_aw = 2'd0; p_acc = 1'b0; p_tk = 1'b0; p_vm = 4'h0;
        r_set = 6'd0; r_aw = 1'b0; r_acc = 1'b0; r_tk = 1'b0; r_vm = 2'b00;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        sb_q.push_back('{"rst_fifo_way", 16'd0});
        sb_q.push_back('{"rst_plru_way", 16'd0});
        sb_q.push_back('{"rst_rand_way", 16'd0});
        sb_q.push_back('{"rst_ready_all", 16'd7});
        e = sb_q.pop_front(); total++;
        if (16'(f_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rw, e.exp); end
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
        e = sb_q.pop_front(); total++;
        if (16'(r_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, r_rw, e.exp); end
        e = sb_q.pop_front(); total++;
        if (16'({f_rdy, p_rdy, r_rdy}) !== e.exp) begin bad++; $display("FAIL %s got=%b%b%b want=111", e.name, f_rdy, p_rdy, r_rdy); end
        tick();
        reset = 1'b0;
        f_vm = 4'hF;
        p_vm = 4'hF;
        @(negedge clk);
        sb_q.push_back('{"post_rst_fifo_full", 16'd0});
        sb_q.push_back('{"post_rst_plru_full", 16'd0});
        e = sb_q.pop_front(); total++;
        if (16'(f_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rw, e.exp); end
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
    endtask

    task automatic test_fifo();
        do_reset();
        f_set = 6'd5;
        f_vm  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back('{$sformatf("fifo_way_%0d", k), 16'(k % 4)});
            @(negedge clk);
            e = sb_q.pop_front(); total++;
            if (16'(f_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rw, e.exp); end
            tick();
            f_tk = 1'b1;
            tick();
            f_tk = 1'b0;
        end
        f_set = 6'd6;
        sb_q.push_back('{"fifo_other_set", 16'd0});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(f_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rw, e.exp); end
        tick();
        f_set = 6'd5;
        f_acc = 1'b1;
        f_aw  = 2'd2;
        tick();
        f_acc = 1'b0;
        sb_q.push_back('{"fifo_access_no_effect", 16'd1});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(f_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rw, e.exp); end
    endtask

    task automatic test_handshake();
        do_reset();
        f_set = 6'd5;
        f_vm  = 4'hF;
        tick();
        f_tk = 1'b1;
        tick();
        sb_q.push_back('{"hs_ready_t1", 16'd0});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(f_rdy) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rdy, e.exp); end
        tick();
        f_tk = 1'b0;
        sb_q.push_back('{"hs_ready_t2", 16'd1});
        sb_q.push_back('{"hs_single_advance", 16'd1});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(f_rdy) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rdy, e.exp); end
        e = sb_q.pop_front(); total++;
        if (16'(f_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rw, e.exp); end
    endtask

    task automatic test_plru();
        do_reset();
        p_set = 6'd3;
        p_vm  = 4'hF;
        sb_q.push_back('{"plru_reset_victim", 16'd0});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
        tick();
        p_acc = 1'b1; p_aw = 2'd0;
        tick();
        p_acc = 1'b0;
        sb_q.push_back('{"plru_after_acc0", 16'd2});
        sb_q.push_back('{"plru_ready_after_acc", 16'd1});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
        e = sb_q.pop_front(); total++;
        if (16'(p_rdy) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rdy, e.exp); end
        tick();
        p_acc = 1'b1; p_aw = 2'd2;
        tick();
        p_acc = 1'b0;
        sb_q.push_back('{"plru_after_acc2", 16'd1});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
        tick();
        p_tk = 1'b1;
        tick();
        p_tk = 1'b0;
        sb_q.push_back('{"plru_after_fill1", 16'd3});
        sb_q.push_back('{"plru_ready_after_fill", 16'd0});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
        e = sb_q.pop_front(); total++;
        if (16'(p_rdy) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rdy, e.exp); end
        p_set = 6'd4;
        #1;
        sb_q.push_back('{"plru_other_set", 16'd0});
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
        p_set = 6'd3;
    endtask

    task automatic test_collision();
        do_reset();
        p_set = 6'd3;
        p_vm  = 4'hF;
        tick();
        p_tk = 1'b1; p_acc = 1'b1; p_aw = 2'd3;
        tick();
        p_tk = 1'b0;
        tick();
        p_acc = 1'b0;
        sb_q.push_back('{"coll_taken_wins", 16'd2});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
        tick();
        p_acc = 1'b1; p_aw = 2'd2;
        tick();
        p_acc = 1'b0;
        sb_q.push_back('{"coll_then_acc2", 16'd1});
        @(negedge clk);
        e = sb_q.pop_front(); total++;
        if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
    endtask

    task automatic test_invalid_pref();
        logic [3:0] masks [4];
        logic [1:0] wants [4];
        masks[0] = 4'b1011; wants[0] = 2'd2;
        masks[1] = 4'b0111; wants[1] = 2'd3;
        masks[2] = 4'b1110; wants[2] = 2'd0;
        masks[3] = 4'b1101; wants[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            f_vm = masks[i];
            p_vm = masks[i];
            sb_q.push_back('{$sformatf("inv_fifo_%b", masks[i]), 16'(wants[i])});
            sb_q.push_back('{$sformatf("inv_plru_%b", masks[i]), 16'(wants[i])});
            #1;
            e = sb_q.pop_front(); total++;
            if (16'(f_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, f_rw, e.exp); end
            e = sb_q.pop_front(); total++;
            if (16'(p_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, p_rw, e.exp); end
        end
        tick();
        r_vm = 2'b01;
        sb_q.push_back('{"inv_rand_01", 16'd1});
        #1;
        e = sb_q.pop_front(); total++;
        if (16'(r_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, r_rw, e.exp); end
        r_vm = 2'b10;
        sb_q.push_back('{"inv_rand_10", 16'd0});
        #1;
        e = sb_q.pop_front(); total++;
        if (16'(r_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, r_rw, e.exp); end
    endtask

    task automatic test_random();
        do_reset();
        r_vm = 2'b11;
        m = 16'hACE1;
        for (int c = 0; c < 40; c++) begin
            sb_q.push_back('{$sformatf("rand_way_c%0d", c), {15'd0, m[0]}});
            if (c == 7) sb_q.push_back('{"rand_ready_low", 16'd0});
            if (c == 8) sb_q.push_back('{"rand_ready_high", 16'd1});
            @(negedge clk);
            e = sb_q.pop_front(); total++;
            if (16'(r_rw) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, r_rw, e.exp); end
            if (c == 7 || c == 8) begin
                e = sb_q.pop_front(); total++;
                if (16'(r_rdy) !== e.exp) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, r_rdy, e.exp); end
            end
            @(posedge clk);
            if (!reset) m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
            #1;
            r_tk  = (c == 5 || c == 11);
            r_acc = (c == 14);
            r_aw  = 1'b1;
            if (c == 20) begin
                reset = 1'b1;
                m = 16'hACE1;
            end
            if (c == 22) reset = 1'b0;
        end
        r_tk  = 1'b0;
        r_acc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fifo();
        test_handshake();
        test_plru();
        test_collision();
        test_invalid_pref();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
